hazard_unit: RTL and testbench

Parametrised hazard and forwarding controller for the pipelined RV32I core. It replaces the purely combinational EX-stage forwarding comparison with a registered in-flight scoreboard. It adds load-use stalls, branch-redirect flushes, memory-busy freezes, and performance counters. The pipeline depth after EX is configurable. It sits beside the ID stage: it observes the decoded instruction in ID and drives PC/IF-ID hold, the ID/EX bubble, the IF/ID flush, and the EX forwarding-mux selects.

---
 rtl/hazard_pkg.sv | 29 ++
 rtl/hazard_unit_sb_match.sv | 31 +++
 rtl/hazard_unit.sv | 123 ++++++++++++
 tb/tb_hazard_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding controller: scoreboard entry, bubble entry, RF forward select.
// No logic of its own; latency and backpressure are defined by the users of these types.
package hazard_pkg;

    // Wide enough for any register address width the core uses; narrower addresses zero-extend.
    localparam int SB_RD_W = 8;

    typedef struct packed {
        logic               valid;
        logic [SB_RD_W-1:0] rd;
        logic               wen;
        logic               is_load;
    } sb_entry_t;

    localparam int        FWD_SEL_RF = 0;
    localparam sb_entry_t SB_BUBBLE  = sb_entry_t'('0);

    // x0 is never a real destination, so it enters the scoreboard as a non-writer.
    function automatic sb_entry_t sb_entry(input logic valid, input logic [SB_RD_W-1:0] rd,
                                           input logic wen, input logic is_load);
        sb_entry_t e;
        e.valid   = valid;
        e.rd      = rd;
        e.wen     = wen && (rd != '0);
        e.is_load = is_load;
        return e;
    endfunction

endpackage

// File: rtl/hazard_unit_sb_match.sv
// Youngest-producer search of the in-flight scoreboard for one source register.
// Purely combinational, zero latency; no flow control of its own.
module sb_match
    import hazard_pkg::*;
#(
    parameter int NUM_ENT = 2,
    parameter int IDX_W   = 2
) (
    input  logic               qual,
    input  logic [SB_RD_W-1:0] src,
    input  sb_entry_t          sb [NUM_ENT],
    output logic               hit,
    output logic [IDX_W-1:0]   idx,
    output logic               is_load
);

    // Walk oldest to youngest so the youngest matching producer wins.
    always_comb begin
        hit     = 1'b0;
        idx     = '0;
        is_load = 1'b0;
        for (int j = NUM_ENT - 1; j >= 0; j--) begin
            if (qual && (src != '0) && sb[j].valid && sb[j].wen && (sb[j].rd == src)) begin
                hit     = 1'b1;
                idx     = IDX_W'(j);
                is_load = sb[j].is_load;
            end
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard/forwarding controller beside ID: load-use stall, redirect flush, memory freeze, EX forward selects.
// Stall/flush outputs are combinational; fwd_sel is registered into EX; mem_busy freezes all state.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int NUM_POST = 2,
    parameter int LOAD_LAT = 1,
    parameter int REG_AW   = 5,
    parameter int CNT_W    = 32,
    parameter int FWD_W    = $clog2(NUM_POST + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wen,
    input  logic              id_is_load,
    input  logic              ex_redirect,
    input  logic              mem_busy,
    output logic              stall_pc,
    output logic              stall_ifid,
    output logic              bubble_idex,
    output logic              flush_ifid,
    output logic              freeze,
    output logic [FWD_W-1:0]  fwd_sel_a,
    output logic [FWD_W-1:0]  fwd_sel_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // Entry k tracks the instruction in EX+k. The WB-side entry is not kept because the
    // register file writes through, so it can never be a forwarding source.
    sb_entry_t sb [NUM_POST];

    logic [SB_RD_W-1:0] rs1_x, rs2_x, rd_x;
    logic               hit_a, hit_b, ld_a, ld_b;
    logic [FWD_W-1:0]   idx_a, idx_b;
    logic               haz_a, haz_b, ld_stall, insert_bubble;

    assign rs1_x = SB_RD_W'(id_rs1);
    assign rs2_x = SB_RD_W'(id_rs2);
    assign rd_x  = SB_RD_W'(id_rd);

    sb_match #(.NUM_ENT(NUM_POST), .IDX_W(FWD_W)) u_match_a (
        .qual    (id_valid && id_use_rs1),
        .src     (rs1_x),
        .sb      (sb),
        .hit     (hit_a),
        .idx     (idx_a),
        .is_load (ld_a)
    );

    sb_match #(.NUM_ENT(NUM_POST), .IDX_W(FWD_W)) u_match_b (
        .qual    (id_valid && id_use_rs2),
        .src     (rs2_x),
        .sb      (sb),
        .hit     (hit_b),
        .idx     (idx_b),
        .is_load (ld_b)
    );

    // A load's data becomes forwardable LOAD_LAT stages after EX.
    assign haz_a         = hit_a && ld_a && (int'(idx_a) < LOAD_LAT);
    assign haz_b         = hit_b && ld_b && (int'(idx_b) < LOAD_LAT);
    assign ld_stall      = haz_a || haz_b;
    assign insert_bubble = ex_redirect || ld_stall;

    always_comb begin
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        bubble_idex = 1'b0;
        flush_ifid  = 1'b0;
        freeze      = mem_busy;
        if (mem_busy) begin
            stall_pc   = 1'b1;
            stall_ifid = 1'b1;
        end else if (ex_redirect) begin
            // The ID instruction is squashed, so any load-use hazard it carries is moot.
            flush_ifid  = 1'b1;
            bubble_idex = 1'b1;
        end else if (ld_stall) begin
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            bubble_idex = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_POST; k++) begin
                sb[k] <= SB_BUBBLE;
            end
            fwd_sel_a <= FWD_W'(FWD_SEL_RF);
            fwd_sel_b <= FWD_W'(FWD_SEL_RF);
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (!mem_busy) begin
            for (int k = NUM_POST - 1; k > 0; k--) begin
                sb[k] <= sb[k-1];
            end
            if (insert_bubble) begin
                sb[0]     <= SB_BUBBLE;
                fwd_sel_a <= FWD_W'(FWD_SEL_RF);
                fwd_sel_b <= FWD_W'(FWD_SEL_RF);
            end else begin
                sb[0]     <= sb_entry(id_valid, rd_x, id_wen, id_is_load);
                fwd_sel_a <= hit_a ? idx_a + FWD_W'(1) : FWD_W'(FWD_SEL_RF);
                fwd_sel_b <= hit_b ? idx_b + FWD_W'(1) : FWD_W'(FWD_SEL_RF);
            end
            if (ld_stall && !ex_redirect && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (ex_redirect && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Two configurations (2/1 with 32-bit counters, 4/3 with 3-bit counters) share one stimulus stream;
// a per-register "youngest in-flight writer" model predicts every output on every cycle.
module tb_hazard_unit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       id_valid, id_use_rs1, id_use_rs2, id_wen, id_is_load, ex_redirect, mem_busy;
    logic [4:0] id_rs1, id_rs2, id_rd;

    logic        spc0, sif0, bub0, fl0, frz0;
    logic [1:0]  fa0, fb0;
    logic [31:0] sc0, fc0;
    logic        spc1, sif1, bub1, fl1, frz1;
    logic [2:0]  fa1, fb1;
    logic [2:0]  sc1, fc1;

    hazard_unit u_dut0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_wen(id_wen),
        .id_is_load(id_is_load), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
        .stall_pc(spc0), .stall_ifid(sif0), .bubble_idex(bub0), .flush_ifid(fl0), .freeze(frz0),
        .fwd_sel_a(fa0), .fwd_sel_b(fb0), .stall_cnt(sc0), .flush_cnt(fc0)
    );

    hazard_unit #(.NUM_POST(4), .LOAD_LAT(3), .CNT_W(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_wen(id_wen),
        .id_is_load(id_is_load), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
        .stall_pc(spc1), .stall_ifid(sif1), .bubble_idex(bub1), .flush_ifid(fl1), .freeze(frz1),
        .fwd_sel_a(fa1), .fwd_sel_b(fb1), .stall_cnt(sc1), .flush_cnt(fc1)
    );

    logic   d_spc [2], d_sif [2], d_bub [2], d_fl [2], d_frz [2];
    longint d_fa [2], d_fb [2], d_sc [2], d_fc [2];
    always_comb begin
        d_spc[0] = spc0; d_sif[0] = sif0; d_bub[0] = bub0; d_fl[0] = fl0; d_frz[0] = frz0;
        d_spc[1] = spc1; d_sif[1] = sif1; d_bub[1] = bub1; d_fl[1] = fl1; d_frz[1] = frz1;
        d_fa[0] = longint'(fa0); d_fb[0] = longint'(fb0); d_sc[0] = longint'(sc0); d_fc[0] = longint'(fc0);
        d_fa[1] = longint'(fa1); d_fb[1] = longint'(fb1); d_sc[1] = longint'(sc1); d_fc[1] = longint'(fc1);
    end

    int     n_chk = 0;
    int     n_pass = 0;
    int     NP [2] = '{2, 4};
    int     LL [2] = '{1, 3};
    longint cmax [2] = '{64'hFFFF_FFFF, 7};

    // Model: for each architectural register, the stage (0 = EX) of its youngest in-flight writer.
    int     prod_stage [2][32];
    bit     prod_load  [2][32];
    longint m_fa [2], m_fb [2], m_sc [2], m_fc [2];
    bit     o_spc [2], o_sif [2], o_bub [2], o_fl [2], o_frz [2];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < 32; r++) begin
                prod_stage[c][r] = -1;
                prod_load[c][r]  = 1'b0;
            end
            m_fa[c] = 0; m_fb[c] = 0; m_sc[c] = 0; m_fc[c] = 0;
        end
    endtask

    function automatic int src_stage(input int c, input logic use_s, input logic [4:0] s);
        if (!id_valid || !use_s || s == 5'd0) return -1;
        return prod_stage[c][s];
    endfunction

    // Compare both DUTs against the model for the current inputs, then advance the model one clock.
    task automatic tick();
        #1;
        for (int c = 0; c < 2; c++) begin
            int sa, sb;
            bit hz, e_spc, e_sif, e_bub, e_fl;
            sa = src_stage(c, id_use_rs1, id_rs1);
            sb = src_stage(c, id_use_rs2, id_rs2);
            hz = (sa >= 0 && prod_load[c][id_rs1] && sa < LL[c]) ||
                 (sb >= 0 && prod_load[c][id_rs2] && sb < LL[c]);
            e_spc = 0; e_sif = 0; e_bub = 0; e_fl = 0;
            if (mem_busy) begin
                e_spc = 1; e_sif = 1;
            end else if (ex_redirect) begin
                e_fl = 1; e_bub = 1;
            end else if (hz) begin
                e_spc = 1; e_sif = 1; e_bub = 1;
            end
            o_spc[c] = d_spc[c]; o_sif[c] = d_sif[c]; o_bub[c] = d_bub[c];
            o_fl[c] = d_fl[c]; o_frz[c] = d_frz[c];
            chk($sformatf("c%0d stall_pc", c), d_spc[c], e_spc);
            chk($sformatf("c%0d stall_ifid", c), d_sif[c], e_sif);
            chk($sformatf("c%0d bubble_idex", c), d_bub[c], e_bub);
            chk($sformatf("c%0d flush_ifid", c), d_fl[c], e_fl);
            chk($sformatf("c%0d freeze", c), d_frz[c], mem_busy);
            chk($sformatf("c%0d fwd_sel_a", c), d_fa[c], m_fa[c]);
            chk($sformatf("c%0d fwd_sel_b", c), d_fb[c], m_fb[c]);
            chk($sformatf("c%0d stall_cnt", c), d_sc[c], m_sc[c]);
            chk($sformatf("c%0d flush_cnt", c), d_fc[c], m_fc[c]);
            if (!mem_busy) begin
                for (int r = 0; r < 32; r++) begin
                    if (prod_stage[c][r] >= 0) begin
                        prod_stage[c][r]++;
                        if (prod_stage[c][r] >= NP[c]) prod_stage[c][r] = -1;
                    end
                end
                if (!ex_redirect && !hz && id_valid && id_wen && id_rd != 5'd0) begin
                    prod_stage[c][id_rd] = 0;
                    prod_load[c][id_rd]  = id_is_load;
                end
                m_fa[c] = (ex_redirect || hz) ? 0 : sa + 1;
                m_fb[c] = (ex_redirect || hz) ? 0 : sb + 1;
                if (hz && !ex_redirect && m_sc[c] < cmax[c]) m_sc[c]++;
                if (ex_redirect && m_fc[c] < cmax[c]) m_fc[c]++;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_id(input logic v, input int rd, input int rs1, input int rs2,
                          input logic u1, input logic u2, input logic wen, input logic ld);
        id_valid = v; id_rd = 5'(rd); id_rs1 = 5'(rs1); id_rs2 = 5'(rs2);
        id_use_rs1 = u1; id_use_rs2 = u2; id_wen = wen; id_is_load = ld;
    endtask

    task automatic drain();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (6) tick();
    endtask

    initial begin
        int nfrz, nst;
        rst_n = 1'b0; ex_redirect = 1'b0; mem_busy = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        chk("rst fwd_sel_a", d_fa[0], 0);
        chk("rst fwd_sel_b", d_fb[0], 0);
        chk("rst stall_cnt", d_sc[0], 0);
        chk("rst flush_cnt", d_fc[0], 0);
        chk("rst stall_pc", d_spc[0], 0);
        tick();

        // ALU producer followed by its consumer: forwarded from EX/MEM, no stall.
        set_id(1, 5, 0, 0, 0, 0, 1, 0); tick();
        set_id(1, 6, 5, 1, 1, 1, 1, 0); tick();
        chk("alu no stall", o_spc[0], 0);
        chk("alu fwd_sel_a", d_fa[0], 1);
        chk("alu fwd_sel_b", d_fb[0], 0);
        drain();

        // Load then dependent: one bubble, then forward from MEM/WB.
        set_id(1, 5, 0, 0, 0, 0, 1, 1); tick();
        set_id(1, 6, 5, 5, 1, 1, 1, 0); tick();
        chk("ld-use stall_pc", o_spc[0], 1);
        chk("ld-use stall_ifid", o_sif[0], 1);
        chk("ld-use bubble", o_bub[0], 1);
        tick();
        chk("ld-use released", o_spc[0], 0);
        chk("ld-use fwd_sel_a", d_fa[0], 2);
        chk("ld-use fwd_sel_b", d_fb[0], 2);
        chk("ld-use stall_cnt", d_sc[0], 1);
        drain();

        // Load, gap, consumer using x0: no stall, x0 never forwarded.
        set_id(1, 5, 0, 0, 0, 0, 1, 1); tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0); tick();
        set_id(1, 6, 5, 0, 1, 1, 1, 0); tick();
        chk("gap no stall", o_spc[0], 0);
        chk("gap fwd_sel_a", d_fa[0], 2);
        chk("gap fwd_sel_b x0", d_fb[0], 0);
        drain();

        // Load-use coinciding with a redirect: flush wins.
        set_id(1, 5, 0, 0, 0, 0, 1, 1); tick();
        set_id(1, 6, 5, 5, 1, 1, 1, 0); ex_redirect = 1'b1; tick(); ex_redirect = 1'b0;
        chk("redir flush", o_fl[0], 1);
        chk("redir bubble", o_bub[0], 1);
        chk("redir stall_pc", o_spc[0], 0);
        chk("redir flush_cnt", d_fc[0], 1);
        chk("redir stall_cnt", d_sc[0], 1);
        chk("redir fwd_sel_a", d_fa[0], 0);
        drain();

        // Memory busy for three cycles in the middle of a dependent chain.
        set_id(1, 1, 0, 0, 0, 0, 1, 0); tick();
        set_id(1, 5, 1, 0, 1, 0, 1, 0); tick();
        chk("pre-busy fwd_sel_a", d_fa[0], 1);
        set_id(1, 6, 5, 1, 1, 1, 1, 0); mem_busy = 1'b1;
        nfrz = 0;
        repeat (3) begin
            tick();
            if (o_frz[0]) nfrz++;
            chk("busy fwd_sel_a hold", d_fa[0], 1);
        end
        chk("busy freeze cycles", nfrz, 3);
        mem_busy = 1'b0; tick();
        chk("post-busy no stall", o_spc[0], 0);
        chk("post-busy fwd_sel_a", d_fa[0], 1);
        chk("post-busy fwd_sel_b", d_fb[0], 2);
        drain();

        // Deep pipe: three stall cycles then forward from WB.
        set_id(1, 7, 0, 0, 0, 0, 1, 1); tick();
        set_id(1, 8, 7, 0, 1, 0, 1, 0);
        nst = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!o_spc[1]) break;
            nst++;
        end
        chk("np4 stall cycles", nst, 3);
        chk("np4 fwd_sel_a", d_fa[1], 4);
        drain();

        for (int i = 0; i < 600; i++) begin
            id_valid    = ($urandom_range(0, 9) < 8);
            id_rs1      = 5'($urandom_range(0, 7));
            id_rs2      = 5'($urandom_range(0, 7));
            id_rd       = 5'($urandom_range(0, 7));
            id_use_rs1  = ($urandom_range(0, 3) != 0);
            id_use_rs2  = ($urandom_range(0, 3) != 0);
            id_wen      = ($urandom_range(0, 4) != 0);
            id_is_load  = ($urandom_range(0, 2) == 0);
            ex_redirect = ($urandom_range(0, 9) == 0);
            mem_busy    = ($urandom_range(0, 9) == 0);
            tick();
        end
        ex_redirect = 1'b0; mem_busy = 1'b0;
        drain();

        // Reset asserted while the deep pipe is stalling clears everything at once.
        set_id(1, 7, 0, 0, 0, 0, 1, 1); tick();
        set_id(1, 8, 7, 0, 1, 0, 1, 0);
        #1;
        chk("pre-rst stall_pc", d_spc[1], 1);
        rst_n = 1'b0;
        #1;
        chk("mid-rst stall_pc", d_spc[1], 0);
        chk("mid-rst stall_ifid", d_sif[1], 0);
        chk("mid-rst bubble", d_bub[1], 0);
        chk("mid-rst flush", d_fl[1], 0);
        chk("mid-rst fwd_sel_a", d_fa[1], 0);
        chk("mid-rst stall_cnt", d_sc[1], 0);
        chk("mid-rst flush_cnt", d_fc[1], 0);
        model_reset();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
